simt_branch_arb: RTL and testbench

SIMT_BRANCH_ARB -- requirements
Module: simt_branch_arb

---
 rtl/simt_branch_arb_pkg.sv | 27 ++
 rtl/simt_branch_arb_rr.sv | 30 +++
 rtl/simt_branch_arb.sv | 174 +++++++++++++++++
 tb/tb_simt_branch_arb.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simt_branch_arb_pkg.sv
// Shared types and constants for the SIMT branch-control arbiter.
// Holds FSM encoding, opcode values, counter width and warp/thread widths.
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif
`ifndef NUM_THREAD
`define NUM_THREAD 8
`endif

package simt_branch_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_MASK = 2'd2
  } state_t;

  localparam logic OP_BRANCH = 1'b0;
  localparam logic OP_JOIN   = 1'b1;

  localparam int CNT_W = 8;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/simt_branch_arb_rr.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
// Ports: req (request vector), ptr (priority start), grant (one-hot out).
module rr_arbiter
  import simt_branch_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simt_branch_arb.sv
// Arbitrates NUM_REQ branch/join requesters onto one SIMT stack port.
// Ports: req_* (requesters), branch_ctl_* (stack), if_mask_* (mask
// return), grant_o/busy_o/err_timeout_o (status).
module simt_branch_arb
  import simt_branch_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ-1:0]             req_opcode_i,
  input  logic [NUM_REQ*`DEPTH_WARP-1:0] req_wid_i,
  input  logic [NUM_REQ*32-1:0]          req_pc_branch_i,
  input  logic [NUM_REQ*32-1:0]          req_pc_execute_i,
  input  logic [NUM_REQ*`NUM_THREAD-1:0] req_mask_init_i,
  output logic                           branch_ctl_valid_o,
  input  logic                           branch_ctl_ready_i,
  output logic                           branch_ctl_opcode_o,
  output logic [`DEPTH_WARP-1:0]         branch_ctl_wid_o,
  output logic [31:0]                    branch_ctl_pc_branch_o,
  output logic [31:0]                    branch_ctl_pc_execute_o,
  output logic [`NUM_THREAD-1:0]         branch_ctl_mask_init_o,
  input  logic                           if_mask_fire_i,
  input  logic [`DEPTH_WARP-1:0]         if_mask_wid_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic                           busy_o,
  output logic                           err_timeout_o
);

  localparam int PW = ptr_w(NUM_REQ);
  localparam int WW = `DEPTH_WARP;
  localparam int TW = `NUM_THREAD;
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  state_t state, state_nxt;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      ptr_nxt;
  logic [NUM_REQ-1:0] arb_grant;
  logic [NUM_REQ-1:0] grant_q;

  logic               op_q;
  logic [WW-1:0]      wid_q;
  logic [31:0]        pcb_q;
  logic [31:0]        pce_q;
  logic [TW-1:0]      mask_q;

  logic [PW-1:0]      win_idx;
  logic               sel_op;
  logic [WW-1:0]      sel_wid;
  logic [31:0]        sel_pcb;
  logic [31:0]        sel_pce;
  logic [TW-1:0]      sel_mask;

  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               err_q;

  logic accept;
  logic handshake;
  logic mask_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PW)
  ) u_rr (
    .req   (req_valid_i),
    .ptr   (rr_ptr),
    .grant (arb_grant)
  );

  // Payload mux driven by the one-hot arbiter grant.
  always_comb begin
    win_idx  = '0;
    sel_op   = 1'b0;
    sel_wid  = '0;
    sel_pcb  = '0;
    sel_pce  = '0;
    sel_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        win_idx  = PW'(i);
        sel_op   = req_opcode_i[i];
        sel_wid  = req_wid_i[i*WW +: WW];
        sel_pcb  = req_pc_branch_i[i*32 +: 32];
        sel_pce  = req_pc_execute_i[i*32 +: 32];
        sel_mask = req_mask_init_i[i*TW +: TW];
      end
    end
  end

  always_comb begin
    if (int'(win_idx) == NUM_REQ - 1) ptr_nxt = '0;
    else ptr_nxt = win_idx + PW'(1);
  end

  assign accept    = (state == IDLE) && (|req_valid_i);
  assign handshake = (state == SEND) && branch_ctl_ready_i;
  assign mask_hit  = if_mask_fire_i && (if_mask_wid_i == wid_q);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = SEND;
      end
      SEND: begin
        if (handshake) begin
          if (op_q == OP_JOIN || mask_hit) state_nxt = IDLE;
          else state_nxt = WAIT_MASK;
        end
      end
      WAIT_MASK: begin
        if (mask_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cnt_nxt = (cnt < TO) ? cnt + CNT_W'(1) : cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant_q <= '0;
      op_q    <= 1'b0;
      wid_q   <= '0;
      pcb_q   <= '0;
      pce_q   <= '0;
      mask_q  <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr_ptr  <= ptr_nxt;
        grant_q <= arb_grant;
        op_q    <= sel_op;
        wid_q   <= sel_wid;
        pcb_q   <= sel_pcb;
        pce_q   <= sel_pce;
        mask_q  <= sel_mask;
      end else if (state_nxt == IDLE) begin
        grant_q <= '0;
      end
      // Every WAIT_MASK cycle counts, including the one that exits.
      if (handshake) begin
        cnt <= '0;
      end else if (state == WAIT_MASK) begin
        cnt <= cnt_nxt;
        if (cnt_nxt == TO) err_q <= 1'b1;
      end
    end
  end

  // rst_n gate keeps ready low for the whole reset, not just after it.
  assign req_ready_o = (state == IDLE && rst_n) ? arb_grant : '0;

  assign branch_ctl_valid_o      = (state == SEND);
  assign branch_ctl_opcode_o     = op_q;
  assign branch_ctl_wid_o        = wid_q;
  assign branch_ctl_pc_branch_o  = pcb_q;
  assign branch_ctl_pc_execute_o = pce_q;
  assign branch_ctl_mask_init_o  = mask_q;

  assign grant_o       = grant_q;
  assign busy_o        = (state != IDLE);
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_simt_branch_arb.sv
// Self-checking bench for simt_branch_arb (NUM_REQ=2, TIMEOUT=4).
// Directed scenarios plus random traffic against a behavioural model.
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif
`ifndef NUM_THREAD
`define NUM_THREAD 8
`endif

module tb_simt_branch_arb;

  localparam int N  = 2;
  localparam int TO = 4;
  localparam int WW = `DEPTH_WARP;
  localparam int TW = `NUM_THREAD;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_opcode;
  logic [N*WW-1:0] req_wid;
  logic [N*32-1:0] req_pcb;
  logic [N*32-1:0] req_pce;
  logic [N*TW-1:0] req_mask;
  logic            bc_valid;
  logic            bc_ready;
  logic            bc_opcode;
  logic [WW-1:0]   bc_wid;
  logic [31:0]     bc_pcb;
  logic [31:0]     bc_pce;
  logic [TW-1:0]   bc_mask;
  logic            fire;
  logic [WW-1:0]   fire_wid;
  logic [N-1:0]    grant;
  logic            busy;
  logic            err;

  int n_cmp;
  int n_bad;

  simt_branch_arb #(
    .NUM_REQ (N),
    .TIMEOUT (TO)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .req_valid_i             (req_valid),
    .req_ready_o             (req_ready),
    .req_opcode_i            (req_opcode),
    .req_wid_i               (req_wid),
    .req_pc_branch_i         (req_pcb),
    .req_pc_execute_i        (req_pce),
    .req_mask_init_i         (req_mask),
    .branch_ctl_valid_o      (bc_valid),
    .branch_ctl_ready_i      (bc_ready),
    .branch_ctl_opcode_o     (bc_opcode),
    .branch_ctl_wid_o        (bc_wid),
    .branch_ctl_pc_branch_o  (bc_pcb),
    .branch_ctl_pc_execute_o (bc_pce),
    .branch_ctl_mask_init_o  (bc_mask),
    .if_mask_fire_i          (fire),
    .if_mask_wid_i           (fire_wid),
    .grant_o                 (grant),
    .busy_o                  (busy),
    .err_timeout_o           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    req_valid  = '0;
    req_opcode = '0;
    req_wid    = '0;
    req_pcb    = '0;
    req_pce    = '0;
    req_mask   = '0;
    bc_ready   = 1'b0;
    fire       = 1'b0;
    fire_wid   = '0;
  endtask

  task automatic set_req(input int k, input logic v, input logic op,
                         input logic [WW-1:0] w, input logic [31:0] pb,
                         input logic [31:0] pe, input logic [TW-1:0] m);
    req_valid[k]           = v;
    req_opcode[k]          = op;
    req_wid[k*WW +: WW]    = w;
    req_pcb[k*32 +: 32]    = pb;
    req_pce[k*32 +: 32]    = pe;
    req_mask[k*TW +: TW]   = m;
  endtask

  task automatic test_reset();
    clear_in();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    #1;
    if ({req_ready, bc_valid, grant, busy, err} !== 7'b0) begin
      $display("FAIL reset_ctl got=%b exp=0",
               {req_ready, bc_valid, grant, busy, err});
      n_bad++;
    end
    n_cmp++;
    if ({bc_opcode, bc_wid, bc_pcb, bc_pce, bc_mask} !== '0) begin
      $display("FAIL reset_payload got=%h exp=0",
               {bc_opcode, bc_wid, bc_pcb, bc_pce, bc_mask});
      n_bad++;
    end
    n_cmp++;
    step();
    req_valid = '0;
    rst_n     = 1'b1;
    step();
  endtask

  task automatic test_rr();
    logic [N-1:0]  exp_g;
    logic [WW-1:0] exp_w;
    clear_in();
    set_req(0, 1'b1, 1'b1, 3'd1, 32'h100, 32'h104, 8'h0F);
    set_req(1, 1'b1, 1'b1, 3'd2, 32'h200, 32'h204, 8'hF0);
    bc_ready = 1'b1;
    for (int a = 0; a < 4; a++) begin
      exp_g = (a % 2 == 0) ? 2'b01 : 2'b10;
      exp_w = (a % 2 == 0) ? 3'd1 : 3'd2;
      #1;
      if (req_ready !== exp_g) begin
        $display("FAIL rr_ready[%0d] got=%b exp=%b", a, req_ready, exp_g);
        n_bad++;
      end
      n_cmp++;
      step();
      if ({bc_valid, grant, bc_wid} !== {1'b1, exp_g, exp_w}) begin
        $display("FAIL rr_send[%0d] got=%b exp=%b", a,
                 {bc_valid, grant, bc_wid}, {1'b1, exp_g, exp_w});
        n_bad++;
      end
      n_cmp++;
      step();
    end
    clear_in();
  endtask

  task automatic test_join_stall();
    clear_in();
    set_req(0, 1'b1, 1'b1, 3'd3, 32'hDEAD_0000, 32'hBEEF_0004, 8'hA5);
    #1;
    if (req_ready !== 2'b01) begin
      $display("FAIL join_accept got=%b exp=01", req_ready);
      n_bad++;
    end
    n_cmp++;
    step();
    set_req(0, 1'b0, 1'b0, 3'd6, $urandom, $urandom, 8'h3C);
    for (int c = 0; c < 4; c++) begin
      #1;
      if ({bc_valid, busy, bc_opcode, bc_wid, bc_pcb, bc_pce, bc_mask} !==
          {3'b111, 3'd3, 32'hDEAD_0000, 32'hBEEF_0004, 8'hA5}) begin
        $display("FAIL join_hold[%0d] got=%h", c,
                 {bc_valid, busy, bc_opcode, bc_wid, bc_pcb, bc_pce, bc_mask});
        n_bad++;
      end
      n_cmp++;
      step();
    end
    bc_ready = 1'b1;
    #1;
    if (bc_valid !== 1'b1) begin
      $display("FAIL join_hs got=%b exp=1", bc_valid);
      n_bad++;
    end
    n_cmp++;
    step();
    bc_ready = 1'b0;
    #1;
    if ({bc_valid, grant, busy} !== 4'b0) begin
      $display("FAIL join_idle got=%b exp=0000", {bc_valid, grant, busy});
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_branch_wid();
    clear_in();
    set_req(1, 1'b1, 1'b0, 3'd2, 32'h300, 32'h304, 8'hFF);
    bc_ready = 1'b1;
    #1;
    if (req_ready !== 2'b10) begin
      $display("FAIL br_accept got=%b exp=10", req_ready);
      n_bad++;
    end
    n_cmp++;
    step();
    req_valid = '0;
    step();
    bc_ready = 1'b0;
    fire     = 1'b1;
    fire_wid = 3'd1;
    #1;
    if ({bc_valid, busy, grant} !== 4'b0110) begin
      $display("FAIL br_wait got=%b exp=0110", {bc_valid, busy, grant});
      n_bad++;
    end
    n_cmp++;
    step();
    fire_wid = 3'd2;
    #1;
    if ({bc_valid, busy, grant} !== 4'b0110) begin
      $display("FAIL br_wrongwid got=%b exp=0110", {bc_valid, busy, grant});
      n_bad++;
    end
    n_cmp++;
    step();
    fire = 1'b0;
    #1;
    if ({busy, grant, err} !== 4'b0) begin
      $display("FAIL br_exit got=%b exp=0000", {busy, grant, err});
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_same_cycle();
    clear_in();
    set_req(0, 1'b1, 1'b0, 3'd5, 32'h400, 32'h404, 8'h11);
    #1;
    if (req_ready !== 2'b01) begin
      $display("FAIL sc_accept got=%b exp=01", req_ready);
      n_bad++;
    end
    n_cmp++;
    step();
    req_valid = '0;
    bc_ready  = 1'b1;
    fire      = 1'b1;
    fire_wid  = 3'd5;
    #1;
    if (bc_valid !== 1'b1) begin
      $display("FAIL sc_send got=%b exp=1", bc_valid);
      n_bad++;
    end
    n_cmp++;
    step();
    clear_in();
    #1;
    if ({bc_valid, busy, grant} !== 4'b0) begin
      $display("FAIL sc_idle got=%b exp=0000", {bc_valid, busy, grant});
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_timeout();
    clear_in();
    set_req(1, 1'b1, 1'b0, 3'd4, 32'h500, 32'h504, 8'h22);
    bc_ready = 1'b1;
    step();
    req_valid = '0;
    step();
    bc_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      if ({busy, err} !== {1'b1, c >= 5}) begin
        $display("FAIL to_wait[%0d] got=%b exp=%b", c, {busy, err},
                 {1'b1, c >= 5});
        n_bad++;
      end
      n_cmp++;
      step();
    end
    fire     = 1'b1;
    fire_wid = 3'd4;
    step();
    fire = 1'b0;
    #1;
    if ({busy, err} !== 2'b01) begin
      $display("FAIL to_exit got=%b exp=01", {busy, err});
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    clear_in();
    set_req(0, 1'b1, 1'b0, 3'd6, 32'h600, 32'h604, 8'h33);
    set_req(1, 1'b0, 1'b1, 3'd7, 32'h700, 32'h704, 8'h44);
    bc_ready = 1'b1;
    step();
    req_valid = '0;
    step();
    bc_ready = 1'b0;
    #1;
    if (busy !== 1'b1) begin
      $display("FAIL rm_wait got=%b exp=1", busy);
      n_bad++;
    end
    n_cmp++;
    req_opcode = 2'b11;
    req_valid  = 2'b11;
    rst_n      = 1'b0;
    #1;
    if ({req_ready, bc_valid, grant, busy, err} !== 7'b0) begin
      $display("FAIL rm_ctl got=%b exp=0",
               {req_ready, bc_valid, grant, busy, err});
      n_bad++;
    end
    n_cmp++;
    if ({bc_opcode, bc_wid, bc_pcb, bc_pce, bc_mask} !== '0) begin
      $display("FAIL rm_payload got=%h exp=0",
               {bc_opcode, bc_wid, bc_pcb, bc_pce, bc_mask});
      n_bad++;
    end
    n_cmp++;
    rst_n = 1'b1;
    #1;
    if (req_ready !== 2'b01) begin
      $display("FAIL rm_rr got=%b exp=01", req_ready);
      n_bad++;
    end
    n_cmp++;
    step();
    req_valid = '0;
    bc_ready  = 1'b1;
    #1;
    if (grant !== 2'b01) begin
      $display("FAIL rm_grant got=%b exp=01", grant);
      n_bad++;
    end
    n_cmp++;
    step();
    clear_in();
  endtask

  task automatic test_random();
    bit            m_hold, m_sent, m_err;
    int            m_ptr, m_own, m_wait, win;
    logic          m_op;
    logic [WW-1:0] m_wid;
    logic [31:0]   m_pcb, m_pce;
    logic [TW-1:0] m_mask;
    logic [N-1:0]  e_ready, e_grant;
    logic          e_valid;
    clear_in();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_hold = 0; m_sent = 0; m_err = 0;
    m_ptr = 0; m_own = 0; m_wait = 0;
    m_op = 0; m_wid = '0; m_pcb = '0; m_pce = '0; m_mask = '0;
    step();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst_n = 1'b0;
        #1;
        rst_n  = 1'b1;
        m_hold = 0; m_sent = 0; m_err = 0; m_ptr = 0;
      end
      for (int k = 0; k < N; k++) begin
        set_req(k, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                WW'($urandom_range(0, 3)), $urandom, $urandom,
                TW'($urandom));
      end
      bc_ready = ($urandom_range(0, 2) != 0);
      fire     = ($urandom_range(0, 1) == 1);
      fire_wid = WW'($urandom_range(0, 3));
      #1;
      win = -1;
      if (!m_hold) begin
        for (int j = 0; j < N; j++) begin
          if (win < 0 && req_valid[(m_ptr + j) % N]) win = (m_ptr + j) % N;
        end
      end
      e_ready = (win >= 0) ? N'(1 << win) : '0;
      e_valid = m_hold && !m_sent;
      e_grant = m_hold ? N'(1 << m_own) : '0;
      if ({req_ready, bc_valid, grant, busy, err} !==
          {e_ready, e_valid, e_grant, m_hold, m_err}) begin
        $display("FAIL rnd_ctl[%0d] got=%b exp=%b", i,
                 {req_ready, bc_valid, grant, busy, err},
                 {e_ready, e_valid, e_grant, m_hold, m_err});
        n_bad++;
      end
      n_cmp++;
      if (e_valid) begin
        if ({bc_opcode, bc_wid, bc_pcb, bc_pce, bc_mask} !==
            {m_op, m_wid, m_pcb, m_pce, m_mask}) begin
          $display("FAIL rnd_payload[%0d] got=%h exp=%h", i,
                   {bc_opcode, bc_wid, bc_pcb, bc_pce, bc_mask},
                   {m_op, m_wid, m_pcb, m_pce, m_mask});
          n_bad++;
        end
        n_cmp++;
      end
      if (!m_hold) begin
        if (win >= 0) begin
          m_hold = 1; m_sent = 0; m_own = win;
          m_ptr  = (win + 1) % N;
          m_op   = req_opcode[win];
          m_wid  = req_wid[win*WW +: WW];
          m_pcb  = req_pcb[win*32 +: 32];
          m_pce  = req_pce[win*32 +: 32];
          m_mask = req_mask[win*TW +: TW];
        end
      end else if (!m_sent) begin
        if (bc_ready) begin
          if (m_op || (fire && fire_wid == m_wid)) m_hold = 0;
          else begin
            m_sent = 1;
            m_wait = 0;
          end
        end
      end else begin
        if (m_wait < TO) m_wait++;
        if (m_wait >= TO) m_err = 1;
        if (fire && fire_wid == m_wid) m_hold = 0;
      end
      step();
    end
    clear_in();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    clear_in();
    test_reset();
    test_rr();
    test_join_stall();
    test_branch_wid();
    test_same_cycle();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
